// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and the BCD mm:ss increment used by the stopwatch.
package stopwatch_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_t;

    // One BCD digit per field; packing order matches {min_bcd, sec_bcd}.
    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_units;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_units;
    } mmss_t;

    // Advance a time by one second; minutes wrap silently to 00 after min_limit.
    function automatic mmss_t mmss_inc(input mmss_t t, input logic [2*BCD_W-1:0] min_limit);
        mmss_t r;
        // NOTE: blocking assignments are correct here because this is pure combinational
        // evaluation; only clocked state uses non-blocking assignments.
        r = t;
        if (t.sec_units != DIGIT_MAX) begin
            r.sec_units = t.sec_units + 4'd1;
        end else begin
            r.sec_units = '0;
            if (t.sec_tens != SEC_TENS_MAX) begin
                r.sec_tens = t.sec_tens + 4'd1;
            end else begin
                r.sec_tens = '0;
                if ({t.min_tens, t.min_units} == min_limit) begin
                    r.min_tens  = '0;
                    r.min_units = '0;
                end else if (t.min_units != DIGIT_MAX) begin
                    r.min_units = t.min_units + 4'd1;
                end else begin
                    r.min_units = '0;
                    r.min_tens  = t.min_tens + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_1hz_btn_sync_edge.sv
// Raw push-button synchroniser followed by a registered rising-edge detector.
// A level held since reset never produces a pulse: an edge is only reported once
// the previous synchronised sample came from a real pin sample, not the reset value.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic BOARD_CLK,
    input  logic BOARD_RST,
    input  logic btn_raw,
    output logic btn_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   prev_q;
    logic                   prev_valid_q;

    // Shift the pin through the synchroniser and emit a one-cycle pulse on a real 0->1.
    always_ff @(posedge BOARD_CLK or posedge BOARD_RST) begin
        if (BOARD_RST) begin
            sync_q       <= '0;
            valid_q      <= '0;
            prev_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            btn_rise     <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            valid_q      <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            prev_q       <= sync_q[SYNC_STAGES-1];
            prev_valid_q <= valid_q[SYNC_STAGES-1];
            btn_rise     <= sync_q[SYNC_STAGES-1] & ~prev_q & prev_valid_q;
        end
    end

endmodule

// File: rtl/stopwatch_bcd_1hz.sv
// BCD mm:ss stopwatch driven by a 1 Hz strobe, with start/stop, clear and lap-hold buttons.
module stopwatch_bcd_1hz
    import stopwatch_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] MIN_LIMIT   = 8'h99
) (
    input  logic       BOARD_CLK,
    input  logic       BOARD_RST,
    input  logic       tick_1hz,
    input  logic       BTN_START,
    input  logic       BTN_CLEAR,
    input  logic       BTN_LAP,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       lap_active,
    output logic [7:0] BOARD_LEDS
);

    logic   start_p, clear_p, lap_p;
    state_t state_q, state_d;
    mmss_t  cnt_q, cnt_d;
    mmss_t  cap_q, cap_d;
    mmss_t  view_d;
    logic   lap_q, lap_d;
    logic   adv;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
        .BOARD_CLK (BOARD_CLK),
        .BOARD_RST (BOARD_RST),
        .btn_raw   (BTN_START),
        .btn_rise  (start_p)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
        .BOARD_CLK (BOARD_CLK),
        .BOARD_RST (BOARD_RST),
        .btn_raw   (BTN_CLEAR),
        .btn_rise  (clear_p)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
        .BOARD_CLK (BOARD_CLK),
        .BOARD_RST (BOARD_RST),
        .btn_raw   (BTN_LAP),
        .btn_rise  (lap_p)
    );

    // Next state, count, lap flag and capture; clear overrides everything else.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        lap_d   = lap_q;
        adv     = tick_1hz && (state_q == S_RUN) && !clear_p;

        if (adv) begin
            cnt_d = mmss_inc(cnt_q, MIN_LIMIT);
        end

        if (clear_p) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            lap_d   = 1'b0;
        end else begin
            if (start_p) begin
                case (state_q)
                    S_IDLE:  state_d = S_RUN;
                    S_RUN:   state_d = S_PAUSE;
                    S_PAUSE: state_d = S_RUN;
                    default: state_d = S_IDLE;
                endcase
            end
            // Capture includes the advance applied at this same edge.
            if (lap_p && (state_q != S_IDLE)) begin
                lap_d = !lap_q;
                if (!lap_q) begin
                    cap_d = cnt_d;
                end
            end
        end

        view_d = lap_d ? cap_d : cnt_d;
    end

    // Register state, count, capture and the outputs derived from their next values.
    always_ff @(posedge BOARD_CLK or posedge BOARD_RST) begin
        if (BOARD_RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cap_q      <= '0;
            lap_q      <= 1'b0;
            sec_bcd    <= '0;
            min_bcd    <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            lap_q      <= lap_d;
            sec_bcd    <= {view_d.sec_tens, view_d.sec_units};
            min_bcd    <= {view_d.min_tens, view_d.min_units};
            running    <= (state_d == S_RUN);
            lap_active <= lap_d;
        end
    end

    assign BOARD_LEDS = sec_bcd;

endmodule

// File: tb/tb_stopwatch_bcd_1hz.sv
// Directed bench for stopwatch_bcd_1hz: one default instance and one with MIN_LIMIT=02.
module tb_stopwatch_bcd_1hz;

    localparam int B_START = 0;
    localparam int B_CLEAR = 1;
    localparam int B_LAP   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [2:0] btn;

    logic [7:0] sec_a, min_a, leds_a;
    logic       run_a, lap_a;
    logic [7:0] sec_b, min_b, leds_b;
    logic       run_b, lap_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_bcd_1hz dut (
        .BOARD_CLK  (clk),
        .BOARD_RST  (rst),
        .tick_1hz   (tick),
        .BTN_START  (btn[B_START]),
        .BTN_CLEAR  (btn[B_CLEAR]),
        .BTN_LAP    (btn[B_LAP]),
        .sec_bcd    (sec_a),
        .min_bcd    (min_a),
        .running    (run_a),
        .lap_active (lap_a),
        .BOARD_LEDS (leds_a)
    );

    stopwatch_bcd_1hz #(.SYNC_STAGES(2), .MIN_LIMIT(8'h02)) dut_w2 (
        .BOARD_CLK  (clk),
        .BOARD_RST  (rst),
        .tick_1hz   (tick),
        .BTN_START  (btn[B_START]),
        .BTN_CLEAR  (btn[B_CLEAR]),
        .BTN_LAP    (btn[B_LAP]),
        .sec_bcd    (sec_b),
        .min_bcd    (min_b),
        .running    (run_b),
        .lap_active (lap_b),
        .BOARD_LEDS (leds_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the whole visible view of the default instance.
    task automatic check_view(input string tag, input logic [7:0] mm, input logic [7:0] ss,
                              input logic r, input logic l);
        check({tag, ".min"},  min_a,           mm);
        check({tag, ".sec"},  sec_a,           ss);
        check({tag, ".leds"}, leds_a,          ss);
        check({tag, ".run"},  {7'd0, run_a},   {7'd0, r});
        check({tag, ".lap"},  {7'd0, lap_a},   {7'd0, l});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    // Press the buttons in mask m; the pulses reach the FSM on the 4th edge, where
    // tick is driven to t. Buttons are then released long enough to re-arm.
    task automatic press(input logic [2:0] m, input logic t);
        btn = m;
        repeat (3) step();
        tick = t;
        step();
        tick = 1'b0;
        btn  = 3'b000;
        repeat (3) step();
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        btn  = 3'b000;
        repeat (3) step();
        check_view("in_reset", 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_view("after_reset", 8'h00, 8'h00, 1'b0, 1'b0);

        // T1: start then 75 ticks.
        press(3'b001, 1'b0);
        check_view("t1_start", 8'h00, 8'h00, 1'b1, 1'b0);
        ticks(75);
        check_view("t1_75s", 8'h01, 8'h15, 1'b1, 1'b0);

        // T2: seconds carry into minutes, and minute wrap at MIN_LIMIT.
        press(3'b010, 1'b0);
        check_view("t2_clear", 8'h00, 8'h00, 1'b0, 1'b0);
        press(3'b001, 1'b0);
        ticks(59);
        check_view("t2_0059", 8'h00, 8'h59, 1'b1, 1'b0);
        ticks(1);
        check_view("t2_0100", 8'h01, 8'h00, 1'b1, 1'b0);
        ticks(119);
        check("t2_w2_0259.min", min_b, 8'h02);
        check("t2_w2_0259.sec", sec_b, 8'h59);
        ticks(1);
        check("t2_w2_wrap.min", min_b, 8'h00);
        check("t2_w2_wrap.sec", sec_b, 8'h00);
        check("t2_w2_wrap.run", {7'd0, run_b}, 8'h01);
        check_view("t2_0300", 8'h03, 8'h00, 1'b1, 1'b0);

        // Default limit: 99:59 wraps to 00:00.
        press(3'b010, 1'b0);
        press(3'b001, 1'b0);
        ticks(5999);
        check_view("t2_9959", 8'h99, 8'h59, 1'b1, 1'b0);
        ticks(1);
        check_view("t2_wrap99", 8'h00, 8'h00, 1'b1, 1'b0);

        // T3: lap hold at 00:10 while the count runs on.
        press(3'b010, 1'b0);
        press(3'b001, 1'b0);
        ticks(10);
        press(3'b100, 1'b0);
        check_view("t3_lap_on", 8'h00, 8'h10, 1'b1, 1'b1);
        ticks(5);
        check_view("t3_frozen", 8'h00, 8'h10, 1'b1, 1'b1);
        press(3'b100, 1'b0);
        check_view("t3_lap_off", 8'h00, 8'h15, 1'b1, 1'b0);

        // Lap capture includes a tick on the same edge.
        press(3'b100, 1'b1);
        check_view("t3_lap_tick", 8'h00, 8'h16, 1'b1, 1'b1);
        ticks(3);
        press(3'b100, 1'b0);
        check_view("t3_lap_tick_off", 8'h00, 8'h19, 1'b1, 1'b0);

        // Lap is ignored in IDLE.
        press(3'b010, 1'b0);
        press(3'b100, 1'b0);
        check_view("t3_lap_idle", 8'h00, 8'h00, 1'b0, 1'b0);

        // T4: clear beats a coincident tick, and beats start.
        press(3'b001, 1'b0);
        ticks(7);
        check_view("t4_0007", 8'h00, 8'h07, 1'b1, 1'b0);
        press(3'b010, 1'b1);
        check_view("t4_clear_tick", 8'h00, 8'h00, 1'b0, 1'b0);
        press(3'b001, 1'b0);
        ticks(4);
        press(3'b100, 1'b0);
        press(3'b011, 1'b0);
        check_view("t4_clear_start", 8'h00, 8'h00, 1'b0, 1'b0);

        // T5: tick with the start leaving IDLE is not counted; pause holds.
        press(3'b001, 1'b1);
        check_view("t5_start_tick", 8'h00, 8'h00, 1'b1, 1'b0);
        press(3'b001, 1'b0);
        check_view("t5_pause", 8'h00, 8'h00, 1'b0, 1'b0);
        press(3'b001, 1'b0);
        ticks(3);
        press(3'b001, 1'b0);
        ticks(10);
        check_view("t5_paused_ticks", 8'h00, 8'h03, 1'b0, 1'b0);
        press(3'b001, 1'b0);
        press(3'b001, 1'b1);
        check_view("t5_pause_tick", 8'h00, 8'h04, 1'b0, 1'b0);

        // T6: asynchronous reset mid-run, start held through release.
        press(3'b010, 1'b0);
        press(3'b001, 1'b0);
        ticks(42);
        check_view("t6_0042", 8'h00, 8'h42, 1'b1, 1'b0);
        #2;
        rst          = 1'b1;
        btn[B_START] = 1'b1;
        #1;
        check_view("t6_async_rst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        check_view("t6_held_start", 8'h00, 8'h00, 1'b0, 1'b0);
        ticks(3);
        check_view("t6_no_count", 8'h00, 8'h00, 1'b0, 1'b0);
        btn = 3'b000;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
